// File: rtl/booth_r4_seq_mul_if.sv
// Operand/result handshake bundle for the iterative radix-4 Booth multiplier.
// The master issues operands and consumes products; the slave is the multiplier.
interface booth_r4_seq_mul_if #(
  parameter int LOGQ = 64
);
  logic [LOGQ-1:0]   in_a;
  logic [LOGQ-1:0]   in_b;
  logic              in_signed;
  logic              in_valid;
  logic              in_ready;
  logic [2*LOGQ-1:0] out_c;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_a, in_b, in_signed, in_valid, out_ready,
    input  in_ready, out_c, out_valid
  );

  modport slave (
    input  in_a, in_b, in_signed, in_valid, out_ready,
    output in_ready, out_c, out_valid
  );
endinterface

// File: rtl/booth_r4_seq_mul.sv
// Iterative radix-4 Booth multiplier: one Booth digit per clock, LOGQ/2+1 digits
// per product, valid/ready handshakes on operands and result.
module booth_r4_seq_mul #(
  parameter int LOGQ = 64
) (
  input logic               clk,
  input logic               rst,
  booth_r4_seq_mul_if.slave bus
);
  localparam int N     = LOGQ / 2 + 1;
  localparam int EXT_W = LOGQ + 2;
  localparam int ACC_W = 2 * LOGQ + 4;
  localparam int CNT_W = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  mcand_q, mcand_d;
  logic [EXT_W:0]    mplr_q, mplr_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [2*LOGQ-1:0] out_c_q, out_c_d;
  logic              out_valid_q, out_valid_d;

  logic [EXT_W-1:0]  a_ext, b_ext;
  logic [ACC_W-1:0]  pp;
  logic              last_digit;

  // Operands are widened by two bits so the unsigned case is a positive signed value.
  always_comb begin
    a_ext = bus.in_signed ? {{2{bus.in_a[LOGQ-1]}}, bus.in_a} : {2'b00, bus.in_a};
    b_ext = bus.in_signed ? {{2{bus.in_b[LOGQ-1]}}, bus.in_b} : {2'b00, bus.in_b};
  end

  // The multiplicand register already carries the 2*i weight, so no barrel shifter.
  always_comb begin
    unique case (mplr_q[2:0])
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = mcand_q << 1;
      3'b100:         pp = -(mcand_q << 1);
      3'b101, 3'b110: pp = -mcand_q;
      default:        pp = '0;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a hold default before the case so no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplr_d      = mplr_q;
    acc_d       = acc_q;
    out_c_d     = out_c_q;
    out_valid_d = out_valid_q;
    last_digit  = (cnt_q == CNT_W'(N - 1));

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mcand_d = {{(ACC_W - EXT_W){a_ext[EXT_W-1]}}, a_ext};
          mplr_d  = {b_ext, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_q + pp;
        mcand_d = mcand_q << 2;
        mplr_d  = {{2{mplr_q[EXT_W]}}, mplr_q[EXT_W:2]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_digit) begin
          out_c_d     = acc_d[2*LOGQ-1:0];
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_c_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_c_q     <= out_c_d;
      out_valid_q <= out_valid_d;
    end
  end

  // NOTE: datapath registers are left unreset; they are always reloaded on acceptance.
  always_ff @(posedge clk) begin
    mcand_q <= mcand_d;
    mplr_q  <= mplr_d;
    acc_q   <= acc_d;
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_c     = out_c_q;
  assign bus.out_valid = out_valid_q;

endmodule
